// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin sharing of the data memory between two req/ack ports,
//            driving clean single-cycle write/read strobes.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_write,
    output logic              mem_writeBack,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] dw_data,
    input  logic [DATA_W-1:0] dr_data,

    output logic              busy,
    output logic              grant_id
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic              r_we_l;
    logic              r_rr_last;

    logic              w_any_req;
    logic              w_grant_port;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // On a tie the port that did not win last time is served.
    always_comb begin
        w_any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            w_grant_port = ~r_rr_last;
        end else begin
            w_grant_port = p1_req;
        end
        w_sel_we    = w_grant_port ? p1_we    : p0_we;
        w_sel_addr  = w_grant_port ? p1_addr  : p0_addr;
        w_sel_wdata = w_grant_port ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_SETUP;
                        busy    <= 1'b1;
                    end
                end
                S_SETUP:  r_state <= S_STROBE;
                S_STROBE: r_state <= S_DONE;
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Request fields are captured only at grant, so the memory-side address and
    // data stay frozen for the whole transaction and hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_addr    <= '0;
            dw_data   <= '0;
            r_we_l    <= 1'b0;
            grant_id  <= 1'b0;
            r_rr_last <= 1'b1;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            d_addr    <= w_sel_addr;
            dw_data   <= w_sel_wdata;
            r_we_l    <= w_sel_we;
            grant_id  <= w_grant_port;
            r_rr_last <= w_grant_port;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_write     <= 1'b0;
            mem_writeBack <= 1'b0;
        end else if (r_state == S_SETUP) begin
            mem_write     <= r_we_l;
            mem_writeBack <= ~r_we_l;
        end else begin
            mem_write     <= 1'b0;
            mem_writeBack <= 1'b0;
        end
    end

    // Read data has been stable since the strobe edge, so it is captured
    // together with the ack as the strobe falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (r_state == S_STROBE) begin
                if (grant_id == 1'b0) begin
                    p0_ack <= 1'b1;
                    if (!r_we_l) begin
                        p0_rdata <= dr_data;
                    end
                end else begin
                    p1_ack <= 1'b1;
                    if (!r_we_l) begin
                        p1_rdata <= dr_data;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Randomized and directed self-checking bench for dmem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              drv_req   [2];
    logic              drv_we    [2];
    logic [7:0]        drv_addr  [2];
    logic [31:0]       drv_wdata [2];
    logic              p0_ack, p1_ack, mem_write, mem_writeBack, busy, grant_id;
    logic [31:0]       p0_rdata, p1_rdata, dw_data;
    logic [31:0]       dr_data;
    logic [7:0]        d_addr;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(drv_req[0]), .p0_we(drv_we[0]), .p0_addr(drv_addr[0]),
        .p0_wdata(drv_wdata[0]), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(drv_req[1]), .p1_we(drv_we[1]), .p1_addr(drv_addr[1]),
        .p1_wdata(drv_wdata[1]), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .mem_writeBack(mem_writeBack),
        .d_addr(d_addr), .dw_data(dw_data), .dr_data(dr_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        case (i)
            1:       return 32'h11;
            2:       return 32'h22;
            3:       return 32'h33;
            32'h20:  return 32'h0;
            default: return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        endcase
    endfunction

    // External data memory reacting to the strobe edges.
    logic [31:0] tb_mem [256];
    int          n_wr_edges = 0;
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = init_val(i);
        dr_data = 32'h0;
        forever begin
            @(posedge mem_write or posedge mem_writeBack);
            if (mem_write) begin
                tb_mem[d_addr] = dw_data;
                n_wr_edges++;
            end
            if (mem_writeBack) dr_data = tb_mem[d_addr];
        end
    end

    // Reference model: each grant starts a 4-edge transaction; outputs are
    // derived from the number of edges elapsed since the grant.
    logic [31:0] ref_mem [256];
    bit          m_valid, m_port, m_we, m_rr_last;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rval;
    logic [31:0] m_rd [2];
    int          m_edges, m_tg;
    initial begin : model
        int d;
        bit pick;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_rval = 32'h0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 1'b0; m_port = 1'b0; m_we = 1'b0; m_rr_last = 1'b1;
                m_addr = 8'h0; m_wdata = 32'h0; m_rd[0] = 32'h0; m_rd[1] = 32'h0;
                m_edges = 0; m_tg = 0;
            end else begin
                d = m_edges - m_tg;
                if (m_valid && d == 1) begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    else      m_rval = ref_mem[m_addr];
                end
                if (m_valid && d == 2 && !m_we) m_rd[m_port] = m_rval;
                if ((!m_valid || d >= 4) && (drv_req[0] || drv_req[1])) begin
                    pick = (drv_req[0] && drv_req[1]) ? !m_rr_last : drv_req[1];
                    m_valid = 1'b1; m_port = pick; m_rr_last = pick; m_tg = m_edges;
                    m_we = drv_we[pick]; m_addr = drv_addr[pick]; m_wdata = drv_wdata[pick];
                end
                m_edges++;
            end
        end
    end

    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            k = m_edges - m_tg;
            check_eq("busy",          busy,          m_valid && k >= 1 && k <= 3);
            check_eq("mem_write",     mem_write,     m_valid && k == 2 && m_we);
            check_eq("mem_writeBack", mem_writeBack, m_valid && k == 2 && !m_we);
            check_eq("p0_ack",        p0_ack,        m_valid && k == 3 && !m_port);
            check_eq("p1_ack",        p1_ack,        m_valid && k == 3 && m_port);
            check_eq("p0_rdata",      p0_rdata,      m_rd[0]);
            check_eq("p1_rdata",      p1_rdata,      m_rd[1]);
            check_eq("d_addr",        d_addr,        m_addr);
            check_eq("dw_data",       dw_data,       m_wdata);
            check_eq("grant_id",      grant_id,      m_port);
            check_eq("strobe_excl",   mem_write & mem_writeBack, 1'b0);
            check_eq("strobe_1cyc",   (mem_write | mem_writeBack) & prev_strobe, 1'b0);
            prev_strobe <= mem_write | mem_writeBack;
        end
    end

    task automatic drive_txn(input bit p, input bit we, input logic [7:0] addr,
                             input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        bit got;
        got = 1'b0; lat = 0; rd = 32'h0;
        drv_req[p] = 1'b1; drv_we[p] = we; drv_addr[p] = addr; drv_wdata[p] = wdata;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (p ? p1_ack : p0_ack) begin
                got = 1'b1;
                rd  = p ? p1_rdata : p0_rdata;
            end
        end
        check_eq("txn_ack_seen", got, 1'b1);
        @(posedge clk); #1;
        drv_req[p] = 1'b0;
    endtask

    task automatic new_req(input int p);
        drv_req[p]   = 1'b1;
        drv_we[p]    = 1'($urandom_range(1, 0));
        drv_addr[p]  = 8'h40 + 8'($urandom_range(7, 0));
        drv_wdata[p] = $urandom;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int          lat, n_ack, n_strobe, n_busy, wr0;
        logic [31:0] rd;
        int          ack_port [8];
        int          ack_cyc  [8];
        logic [31:0] ack_rd   [8];
        bit          acks [2];

        for (int p = 0; p < 2; p++) begin
            drv_req[p] = 1'b0; drv_we[p] = 1'b0; drv_addr[p] = 8'h0; drv_wdata[p] = 32'h0;
        end
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_strobes", {mem_write, mem_writeBack}, 2'b00);
        check_eq("rst_d_addr", d_addr, 8'h0);
        check_eq("rst_dw_data", dw_data, 32'h0);
        check_eq("rst_acks", {p0_ack, p1_ack}, 2'b00);
        check_eq("rst_p0_rdata", p0_rdata, 32'h0);
        check_eq("rst_grant_id", grant_id, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Single write then read on port 0.
        wr0 = n_wr_edges;
        drive_txn(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, lat, rd);
        check_eq("wr_latency", lat, 3);
        check_eq("wr_edges", n_wr_edges - wr0, 1);
        check_eq("mem_0x10", tb_mem[8'h10], 32'hDEADBEEF);
        drive_txn(1'b0, 1'b0, 8'h10, 32'h0, lat, rd);
        check_eq("rd_latency", lat, 3);
        check_eq("rd_data_0x10", rd, 32'hDEADBEEF);

        // Contention from reset: alternating service starting with port 0.
        pulse_reset();
        drv_we[0] = 1'b0; drv_addr[0] = 8'h01;
        drv_we[1] = 1'b0; drv_addr[1] = 8'h02;
        drv_req[0] = 1'b1; drv_req[1] = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 40 && n_ack < 6; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                ack_port[n_ack] = p1_ack ? 1 : 0;
                ack_cyc[n_ack]  = cyc;
                n_ack++;
            end
        end
        @(posedge clk); #1;
        drv_req[0] = 1'b0; drv_req[1] = 1'b0;
        check_eq("cont_acks", n_ack, 6);
        for (int i = 0; i < n_ack; i++) begin
            check_eq("cont_order", ack_port[i], i % 2);
            if (i > 0) check_eq("cont_gap", ack_cyc[i] - ack_cyc[i-1], 4);
        end

        // Back-to-back reads on port 1.
        drv_we[1] = 1'b0; drv_addr[1] = 8'h01; drv_req[1] = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 40 && n_ack < 3; i++) begin
            @(negedge clk);
            if (p1_ack) begin
                ack_rd[n_ack]  = p1_rdata;
                ack_cyc[n_ack] = cyc;
                n_ack++;
                @(posedge clk); #1;
                if (n_ack < 3) drv_addr[1] = 8'(n_ack + 1);
                else           drv_req[1]  = 1'b0;
            end
        end
        check_eq("b2b_acks", n_ack, 3);
        for (int i = 0; i < n_ack; i++) begin
            check_eq("b2b_rdata", ack_rd[i], 32'h11 * (i + 1));
            if (i > 0) check_eq("b2b_gap", ack_cyc[i] - ack_cyc[i-1], 4);
        end
        check_eq("b2b_p0_rdata_kept", p0_rdata, 32'h11);

        // Reset during SETUP of a write to 0x20.
        wr0 = n_wr_edges;
        drv_we[0] = 1'b1; drv_addr[0] = 8'h20; drv_wdata[0] = 32'hCAFEF00D; drv_req[0] = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        drv_req[0] = 1'b0;
        #1;
        check_eq("midrst_outputs",
                 {31'h0, busy | mem_write | mem_writeBack | p0_ack | p1_ack | grant_id}, 32'h0);
        check_eq("midrst_d_addr", d_addr, 8'h0);
        check_eq("midrst_rdata", p0_rdata | p1_rdata | dw_data, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("midrst_no_write", n_wr_edges - wr0, 0);
        check_eq("midrst_mem_0x20", tb_mem[8'h20], 32'h0);
        drv_we[0] = 1'b0; drv_addr[0] = 8'h20;
        drv_we[1] = 1'b0; drv_addr[1] = 8'h03;
        drv_req[0] = 1'b1; drv_req[1] = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 30 && drv_req[1]; i++) begin
            @(negedge clk);
            acks[0] = p0_ack; acks[1] = p1_ack;
            if (acks[0] || acks[1]) begin
                if (n_ack == 0) check_eq("midrst_first_p0", acks[0], 1'b1);
                n_ack++;
                @(posedge clk); #1;
                if (acks[0]) drv_req[0] = 1'b0;
                if (acks[1]) drv_req[1] = 1'b0;
            end
        end
        drv_req[0] = 1'b0; drv_req[1] = 1'b0;
        check_eq("midrst_acks", n_ack, 2);

        // Idle: nothing moves without requests.
        n_ack = 0; n_strobe = 0; n_busy = 0;
        repeat (20) begin
            @(negedge clk);
            n_ack    += int'(p0_ack) + int'(p1_ack);
            n_strobe += int'(mem_write) + int'(mem_writeBack);
            n_busy   += int'(busy);
        end
        check_eq("idle_acks", n_ack, 0);
        check_eq("idle_strobes", n_strobe, 0);
        check_eq("idle_busy", n_busy, 0);

        // Randomized mixed traffic, then drain.
        n_ack = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            acks[0] = p0_ack; acks[1] = p1_ack;
            n_ack += int'(acks[0]) + int'(acks[1]);
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (drv_req[p]) begin
                    if (acks[p]) begin
                        if (c < 660 && $urandom_range(1, 0) == 1) new_req(p);
                        else drv_req[p] = 1'b0;
                    end
                end else if (c < 660 && $urandom_range(99, 0) < 35) begin
                    new_req(p);
                end
            end
        end
        check_eq("rand_drained", {31'h0, drv_req[0] | drv_req[1]}, 32'h0);
        check_eq("rand_activity", n_ack > 60, 1'b1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
